// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo buffer.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitHi,
        StWaitLo
    } echo_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Count must hold 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_echo_buffer_if.sv
// Handshake/status bundle between UART_Rx/UART_Tx glue and the echo buffer.
interface uart_echo_buffer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) ();

    localparam int unsigned CNT_W = uart_pkg::cnt_w(DEPTH);

    logic              en;
    logic              rx_val;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              tx_val;
    logic [DATA_W-1:0] tx_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              empty;
    logic              full;
    logic              overrun;
    logic              clr_ovr;

    modport master (
        output en, rx_val, rx_data, busy, clr_ovr,
        input  tx_val, tx_data, fifo_count, empty, full, overrun
    );

    modport slave (
        input  en, rx_val, rx_data, busy, clr_ovr,
        output tx_val, tx_data, fifo_count, empty, full, overrun
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and registered empty/full.
module sync_fifo import uart_pkg::*; #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      empty,
    output logic                      full
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, full_q;
    logic              do_wr, do_rd;

    // A write into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full_q || rd_en);
    assign do_rd = rd_en && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + PTR_W'(1);
            if (do_rd) rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rptr_q];
    assign count   = count_q;
    assign empty   = empty_q;
    assign full    = full_q;

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffers words from UART_Rx and re-issues them to UART_Tx, with busy-timeout retry
// and optional CR -> CR+LF expansion.
module uart_echo_buffer import uart_pkg::*; #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned BUSY_TO = 64,
    parameter int unsigned CRLF_EN = 0
) (
    input logic              clk,
    input logic              rst,
    uart_echo_buffer_if.slave bus
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam int unsigned TO_W  = $clog2(BUSY_TO);

    echo_state_e       state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              crlf_pend_q, crlf_pend_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              ovr_q, ovr_d;

    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  count;
    logic              f_empty, f_full;
    logic              start, pop, wr, drop;

    assign start = (state_q == StIdle) && bus.en && !bus.busy && (crlf_pend_q || !f_empty);
    // A pending LF is issued from the holding register without touching the FIFO.
    assign pop   = start && !crlf_pend_q;
    assign wr    = bus.rx_val && (!f_full || pop);
    assign drop  = bus.rx_val && f_full && !pop;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr),
        .wr_data (bus.rx_data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count),
        .empty   (f_empty),
        .full    (f_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            crlf_pend_q <= 1'b0;
            to_cnt_q    <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            crlf_pend_q <= crlf_pend_d;
            to_cnt_q    <= to_cnt_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        crlf_pend_d = crlf_pend_q;
        to_cnt_d    = to_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    if (crlf_pend_q) begin
                        hold_d      = DATA_W'(ASCII_LF);
                        crlf_pend_d = 1'b0;
                    end else begin
                        hold_d      = head;
                        crlf_pend_d = (CRLF_EN != 0) && (head == DATA_W'(ASCII_CR));
                    end
                end
            end
            StIssue: begin
                state_d  = StWaitHi;
                to_cnt_d = '0;
            end
            StWaitHi: begin
                if (bus.busy) begin
                    state_d = StWaitLo;
                end else if (to_cnt_q == TO_W'(BUSY_TO - 1)) begin
                    state_d = StIssue;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            StWaitLo: begin
                if (!bus.busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Set wins over clear.
    always_comb begin
        ovr_d = ovr_q;
        if (drop) begin
            ovr_d = 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_comb begin
        bus.tx_val     = (state_q == StIssue);
        bus.tx_data    = hold_q;
        bus.fifo_count = count;
        bus.empty      = f_empty;
        bus.full       = f_full;
        bus.overrun    = ovr_q;
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer: plain instance plus a CRLF-enabled instance.
module tb_uart_echo_buffer;

    localparam int unsigned DW  = 8;
    localparam int unsigned DP  = 16;
    localparam int unsigned BTO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_echo_buffer_if #(.DATA_W(DW), .DEPTH(DP)) b0 ();
    uart_echo_buffer_if #(.DATA_W(DW), .DEPTH(DP)) b1 ();

    uart_echo_buffer #(.DATA_W(DW), .DEPTH(DP), .BUSY_TO(BTO), .CRLF_EN(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    uart_echo_buffer #(.DATA_W(DW), .DEPTH(DP), .BUSY_TO(BTO), .CRLF_EN(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    int   errors = 0;
    int   checks = 0;
    logic busy_auto = 1'b1;
    logic busy_man  = 1'b0;
    logic busy_m0   = 1'b0;
    logic busy_m1   = 1'b0;
    int   frame0    = 100;
    logic [7:0] txq0[$];
    logic [7:0] txq1[$];

    assign b0.busy = busy_auto ? busy_m0 : busy_man;
    assign b1.busy = busy_m1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic send0(input logic [7:0] d);
        b0.rx_val  = 1'b1;
        b0.rx_data = d;
        tick();
        b0.rx_val  = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d);
        b1.rx_val  = 1'b1;
        b1.rx_data = d;
        tick();
        b1.rx_val  = 1'b0;
    endtask

    task automatic wait_tx0(input string tag, input int lim);
        int n = 0;
        while (!b0.tx_val && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 32'(b0.tx_val), 1);
    endtask

    // UART_Tx busy model: rises 5 cycles after an issue, stays high for a frame.
    initial begin : model0
        int f;
        forever begin
            @(negedge clk);
            if (b0.tx_val && !rst) begin
                f = frame0;
                for (int i = 0; i < 5 && !rst; i++) @(negedge clk);
                if (!rst) busy_m0 = 1'b1;
                for (int i = 0; i < f && !rst; i++) @(negedge clk);
                busy_m0 = 1'b0;
            end
        end
    end

    initial begin : model1
        forever begin
            @(negedge clk);
            if (b1.tx_val && !rst) begin
                for (int i = 0; i < 5 && !rst; i++) @(negedge clk);
                if (!rst) busy_m1 = 1'b1;
                for (int i = 0; i < 10 && !rst; i++) @(negedge clk);
                busy_m1 = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (b0.tx_val) txq0.push_back(b0.tx_data);
            if (b1.tx_val) txq1.push_back(b1.tx_data);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int         base;
        logic       stable;
        logic [7:0] exp5 [4];

        b0.en = 1'b1; b0.rx_val = 1'b0; b0.rx_data = '0; b0.clr_ovr = 1'b0;
        b1.en = 1'b1; b1.rx_val = 1'b0; b1.rx_data = '0; b1.clr_ovr = 1'b0;

        // Reset values
        rst = 1'b1;
        tick(2);
        chk("rst_tx_val", 32'(b0.tx_val), 0);
        chk("rst_tx_data", 32'(b0.tx_data), 0);
        chk("rst_count", 32'(b0.fifo_count), 0);
        chk("rst_empty", 32'(b0.empty), 1);
        chk("rst_full", 32'(b0.full), 0);
        chk("rst_ovr", 32'(b0.overrun), 0);
        rst = 1'b0;
        tick(2);

        // Single byte, 2-cycle latency
        send0(8'hAC);
        chk("lat_wr_count", 32'(b0.fifo_count), 1);
        chk("lat_no_early", 32'(b0.tx_val), 0);
        tick();
        chk("lat_tx_val", 32'(b0.tx_val), 1);
        chk("lat_tx_data", 32'(b0.tx_data), 'hAC);
        chk("lat_pop_count", 32'(b0.fifo_count), 0);
        stable = 1'b1;
        for (int i = 0; i < 104; i++) begin
            tick();
            if (b0.tx_data !== 8'hAC) stable = 1'b0;
        end
        chk("single_stable", 32'(stable), 1);
        tick(10);
        #1;
        chk("single_txcnt", txq0.size(), 1);
        chk("single_data", 32'(txq0[0]), 'hAC);
        chk("single_empty", 32'(b0.empty), 1);
        tick();

        // Burst of 20 into a 16-deep FIFO behind a long frame
        frame0 = 400;
        base = txq0.size();
        for (int i = 1; i <= 20; i++) begin
            b0.rx_val  = 1'b1;
            b0.rx_data = 8'(i);
            tick();
        end
        b0.rx_val = 1'b0;
        chk("burst_count_full", 32'(b0.fifo_count), 16);
        chk("burst_full", 32'(b0.full), 1);
        chk("burst_ovr", 32'(b0.overrun), 1);
        #1;
        chk("burst_first_issued", txq0.size() - base, 1);
        frame0 = 20;
        tick(1400);
        chk("burst_ovr_hold", 32'(b0.overrun), 1);
        chk("burst_empty", 32'(b0.empty), 1);
        #1;
        chk("burst_txcnt", txq0.size() - base, 17);
        for (int i = 0; i < 17; i++) chk("burst_order", 32'(txq0[base + i]), i + 1);
        tick();
        b0.clr_ovr = 1'b1;
        tick();
        b0.clr_ovr = 1'b0;
        chk("clr_ovr", 32'(b0.overrun), 0);

        // Push into a full FIFO on the pop cycle
        base = txq0.size();
        b0.en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b0.rx_val  = 1'b1;
            b0.rx_data = 8'(8'hA0 + i);
            tick();
        end
        chk("pp_full_pre", 32'(b0.full), 1);
        b0.en      = 1'b1;
        b0.rx_data = 8'hB0;
        tick();
        b0.rx_val = 1'b0;
        chk("pp_count", 32'(b0.fifo_count), 16);
        chk("pp_full", 32'(b0.full), 1);
        chk("pp_ovr", 32'(b0.overrun), 0);
        chk("pp_tx_val", 32'(b0.tx_val), 1);
        chk("pp_tx_data", 32'(b0.tx_data), 'hA0);
        tick(600);
        #1;
        chk("pp_txcnt", txq0.size() - base, 17);
        chk("pp_last", 32'(txq0[txq0.size() - 1]), 'hB0);
        tick();

        // Busy never rises: retry every BUSY_TO+1 cycles
        busy_auto = 1'b0;
        busy_man  = 1'b0;
        send0(8'h55);
        tick();
        chk("to_first", 32'(b0.tx_val), 1);
        chk("to_first_data", 32'(b0.tx_data), 'h55);
        tick(10);
        send0(8'h66);
        tick(53);
        chk("to_gap", 32'(b0.tx_val), 0);
        tick();
        chk("to_retry1", 32'(b0.tx_val), 1);
        chk("to_retry1_data", 32'(b0.tx_data), 'h55);
        chk("to_retry1_count", 32'(b0.fifo_count), 1);
        tick(65);
        chk("to_retry2", 32'(b0.tx_val), 1);
        chk("to_retry2_data", 32'(b0.tx_data), 'h55);
        chk("to_retry2_count", 32'(b0.fifo_count), 1);
        busy_man = 1'b1;
        tick(3);
        busy_man = 1'b0;
        wait_tx0("to_next", 20);
        chk("to_next_data", 32'(b0.tx_data), 'h66);
        chk("to_next_count", 32'(b0.fifo_count), 0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        busy_auto = 1'b1;
        tick(2);

        // CR -> CR+LF expansion
        send1(8'h41);
        send1(8'h0D);
        send1(8'h42);
        tick(300);
        #1;
        exp5[0] = 8'h41; exp5[1] = 8'h0D; exp5[2] = 8'h0A; exp5[3] = 8'h42;
        chk("crlf_cnt", txq1.size(), 4);
        for (int i = 0; i < 4; i++) chk("crlf_seq", 32'(txq1[i]), 32'(exp5[i]));
        tick();

        // Asynchronous reset while in WAIT_LO with 5 queued
        frame0 = 100;
        for (int i = 0; i < 6; i++) begin
            b0.rx_val  = 1'b1;
            b0.rx_data = 8'(8'hC1 + i);
            tick();
        end
        b0.rx_val = 1'b0;
        tick(10);
        chk("mid_busy", 32'(b0.busy), 1);
        chk("mid_count", 32'(b0.fifo_count), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tx_val", 32'(b0.tx_val), 0);
        chk("arst_tx_data", 32'(b0.tx_data), 0);
        chk("arst_count", 32'(b0.fifo_count), 0);
        chk("arst_empty", 32'(b0.empty), 1);
        chk("arst_full", 32'(b0.full), 0);
        tick();
        #2;
        rst = 1'b0;
        base = txq0.size();
        tick(200);
        #1;
        chk("arst_no_tx", txq0.size() - base, 0);
        tick();
        send0(8'h77);
        tick();
        chk("arst_new_tx", 32'(b0.tx_val), 1);
        chk("arst_new_data", 32'(b0.tx_data), 'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
